// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: registered hsync/vsync, display enable, pixel
// coordinates and line/frame strobes, all describing the same pixel each cycle.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // One spare bit so region bounds equal to 1024 still compare correctly.
    localparam int unsigned CW      = 11;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
    localparam logic [CW-1:0] H_SS   = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] H_SE   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
    localparam logic [CW-1:0] V_SS   = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] V_SE   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic       started;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic [7:0] f_nxt;
    logic       hs_act;
    logic       vs_act;
    logic       de_nxt;

    // Next pixel: (0,0) on the first cycle after reset, else raster advance.
    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        f_nxt = frame_cnt;
        if (started) begin
            if (CW'(hpos) == H_LAST) begin
                if (CW'(vpos) == V_LAST) begin
                    f_nxt = frame_cnt + 8'd1;
                end else begin
                    v_nxt = vpos + 10'd1;
                end
            end else begin
                h_nxt = hpos + 10'd1;
                v_nxt = vpos;
            end
        end
        hs_act = (CW'(h_nxt) >= H_SS) && (CW'(h_nxt) < H_SE);
        vs_act = (CW'(v_nxt) >= V_SS) && (CW'(v_nxt) < V_SE);
        de_nxt = (CW'(h_nxt) < H_VIS) && (CW'(v_nxt) < V_VIS);
    end

    // Decoded flags are registered with the coordinates they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            frame_cnt   <= '0;
            hsync       <= SYNC_ACTIVE_LOW;
            vsync       <= SYNC_ACTIVE_LOW;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            started     <= 1'b1;
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            frame_cnt   <= f_nxt;
            hsync       <= hs_act ^ SYNC_ACTIVE_LOW;
            vsync       <= vs_act ^ SYNC_ACTIVE_LOW;
            display_on  <= de_nxt;
            line_start  <= (h_nxt == 10'd0);
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three geometries share clock and reset,
// expected pixels come from a pixel-index model and are checked by a monitor.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       disp;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } pix_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_h, d_v;
    logic [7:0] d_fc;
    logic       m_hs, m_vs, m_de, m_ls, m_fs;
    logic [9:0] m_h, m_v;
    logic [7:0] m_fc;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_h, s_v;
    logic [7:0] s_fc;

    vga_sync_gen u_def (
        .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
        .hpos(d_h), .vpos(d_v), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_sync_gen #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_LOW(1'b1)
    ) u_mid (
        .clk(clk), .rst_n(rst_n), .hsync(m_hs), .vsync(m_vs), .display_on(m_de),
        .hpos(m_h), .vpos(m_v), .line_start(m_ls), .frame_start(m_fs), .frame_cnt(m_fc)
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1'b0)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
        .hpos(s_h), .vpos(s_v), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    pix_t d_pix, m_pix, s_pix;
    assign d_pix = {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_fc};
    assign m_pix = {m_h, m_v, m_hs, m_vs, m_de, m_ls, m_fs, m_fc};
    assign s_pix = {s_h, s_v, s_hs, s_vs, s_de, s_ls, s_fs, s_fc};

    pix_t q_def[$];
    pix_t q_mid[$];
    pix_t q_sml[$];
    int   t      = -1;
    int   errors = 0;
    int   checks = 0;

    // Pixel presented tt cycles after the first post-reset edge (tt < 0: in reset).
    function automatic pix_t ref_pix(input int hv, input int hf, input int hs, input int hb,
                                     input int vv, input int vf, input int vs, input int vb,
                                     input bit al, input int tt);
        pix_t p;
        int ht, vt, idx, h, v;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        p  = '0;
        if (tt < 0) begin
            p.hsync = al;
            p.vsync = al;
            return p;
        end
        idx     = tt % (ht * vt);
        h       = idx % ht;
        v       = idx / ht;
        p.hpos  = 10'(h);
        p.vpos  = 10'(v);
        p.hsync = al ^ ((h >= hv + hf) && (h < hv + hf + hs));
        p.vsync = al ^ ((v >= vv + vf) && (v < vv + vf + vs));
        p.disp  = (h < hv) && (v < vv);
        p.ls    = (h == 0);
        p.fs    = (idx == 0);
        p.fc    = 8'((tt / (ht * vt)) % 256);
        return p;
    endfunction

    // Reference: push the pixel each design should present after this event.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t = -1;
        else        t = t + 1;
        q_def.push_back(ref_pix(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, t));
        q_mid.push_back(ref_pix(40, 4, 8, 4, 20, 2, 2, 3, 1'b1, t));
        q_sml.push_back(ref_pix(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, t));
    end

    task automatic check(input string name, input pix_t act, input pix_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     name, t, act.hpos, act.vpos, act.hsync, act.vsync, act.disp, act.ls, act.fs, act.fc,
                     exp.hpos, exp.vpos, exp.hsync, exp.vsync, exp.disp, exp.ls, exp.fs, exp.fc);
            if (errors >= 25) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    // Monitor: compare settled outputs against queued expectations.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        while (q_def.size() > 0) check("default", d_pix, q_def.pop_front());
        while (q_mid.size() > 0) check("mid", m_pix, q_mid.pop_front());
        while (q_sml.size() > 0) check("small", s_pix, q_sml.pop_front());
    end

    task automatic set_rst(input logic v);
        @(negedge clk);
        #3;
        rst_n = v;
    endtask

    initial begin
        repeat ($urandom_range(3, 8)) @(posedge clk);
        set_rst(1'b1);
        // Long enough for 256+ small frames (98 cycles each) to see frame_cnt wrap.
        repeat (25400) @(posedge clk);
        // Reset while the mid geometry sits inside both sync pulses (h=50, v=22).
        for (int k = 0; k < 1600 && (t % 1512) != 22 * 56 + 50; k++) @(posedge clk);
        set_rst(1'b0);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        set_rst(1'b1);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(200, 3000)) @(posedge clk);
            set_rst(1'b0);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            set_rst(1'b1);
        end
        repeat (2000) @(posedge clk);
        @(negedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
